// File: rtl/sram_stream_pkg.sv
// sram_stream_pkg: shared types and constants for the SRAM streamer.
// Optional write path is enabled by defining SRAM_STREAM_WR_EN.
package sram_stream_pkg;

  // Controller states; WRITE is only reachable when SRAM_STREAM_WR_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Skid FIFO depth and the width of its occupancy counter.
  localparam int SRAM_STREAM_FIFO_DEPTH = 2;
  localparam int SRAM_STREAM_CNT_W      = 2;

  // Words held after this cycle: buffered + arriving from the SRAM - leaving downstream.
  function automatic logic [2:0] stream_occupancy(
    input logic [SRAM_STREAM_CNT_W-1:0] count,
    input logic                         inflight,
    input logic                         pop
  );
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/sram_stream_if.sv
// sram_stream_if: command, read-stream, optional write-stream and SRAM bus
// of the streamer. The write-stream signals exist only with SRAM_STREAM_WR_EN.
interface sram_stream_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef SRAM_STREAM_WR_EN
  logic                  cmd_wr;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic                  sram_wr;
  logic [DATA_WIDTH-1:0] sram_qout;

`ifdef SRAM_STREAM_WR_EN
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_wr, in_valid, in_data, out_ready, sram_qout,
    output cmd_ready, in_ready, out_valid, out_data, out_last, busy, done,
           sram_addr, sram_din, sram_wr
  );
  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_wr, in_valid, in_data, out_ready, sram_qout,
    input  cmd_ready, in_ready, out_valid, out_data, out_last, busy, done,
           sram_addr, sram_din, sram_wr
  );
`else
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready, sram_qout,
    output cmd_ready, out_valid, out_data, out_last, busy, done,
           sram_addr, sram_din, sram_wr
  );
  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready, sram_qout,
    input  cmd_ready, out_valid, out_data, out_last, busy, done,
           sram_addr, sram_din, sram_wr
  );
`endif

endinterface

// File: rtl/sram_stream_skid.sv
// sram_stream_skid: 2-entry shift FIFO that absorbs the SRAM read latency.
// Entry 0 is always the head. Each entry carries a last-word flag.
// Independent of SRAM_STREAM_WR_EN.
module sram_stream_skid
  import sram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         push_last,
  input  logic                         pop,
  output logic [SRAM_STREAM_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic                         head_last
);

  logic [SRAM_STREAM_CNT_W-1:0] count_r;
  logic [DATA_WIDTH-1:0]        data0_r, data1_r;
  logic                         last0_r, last1_r;

  assign count     = count_r;
  assign head_data = data0_r;
  assign head_last = last0_r;

  // Shift-register FIFO: a pop moves entry 1 to the head, a push fills the first free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
      data0_r <= '0;
      data1_r <= '0;
      last0_r <= 1'b0;
      last1_r <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            data0_r <= push_data;
            last0_r <= push_last;
          end else begin
            data1_r <= push_data;
            last1_r <= push_last;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          data0_r <= data1_r;
          last0_r <= last1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            data0_r <= push_data;
            last0_r <= push_last;
          end else begin
            data0_r <= data1_r;
            last0_r <= last1_r;
            data1_r <= push_data;
            last1_r <= push_last;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_stream.sv
// sram_stream: turns (addr, len) commands into consecutive single-port SRAM
// reads and presents the words as a valid/ready stream with a last flag.
// Define SRAM_STREAM_WR_EN to add write commands fed by an input stream.
module sram_stream
  import sram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic          clk,
  input logic          rst_n,
  sram_stream_if.slave bus
);

  state_t                       state_r, state_nx_s;
  logic [ADDR_WIDTH-1:0]        ptr_r;
  logic [ADDR_WIDTH-1:0]        addr_hold_r;
  logic [LEN_WIDTH-1:0]         remain_r;
  logic                         inflight_r;
  logic                         inflight_last_r;
  logic                         cmd_hs_s;
  logic                         cmd_is_wr_s;
  logic                         issue_s;
  logic                         wr_hs_s;
  logic                         pop_s;
  logic                         fifo_valid_s;
  logic [SRAM_STREAM_CNT_W-1:0] fifo_count_s;
  logic [DATA_WIDTH-1:0]        head_data_s;
  logic                         head_last_s;

  assign bus.cmd_ready = (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = (state_r == FINISH);
  assign cmd_hs_s      = bus.cmd_valid & bus.cmd_ready;

  assign fifo_valid_s  = (fifo_count_s != 2'd0);
  assign pop_s         = fifo_valid_s & bus.out_ready;
  assign bus.out_valid = fifo_valid_s;
  assign bus.out_data  = head_data_s;
  assign bus.out_last  = fifo_valid_s & head_last_s;

`ifdef SRAM_STREAM_WR_EN
  assign cmd_is_wr_s  = bus.cmd_wr;
  assign bus.in_ready = (state_r == WRITE) && (remain_r != '0);
  assign wr_hs_s      = bus.in_ready & bus.in_valid;
  assign bus.sram_wr  = wr_hs_s;
  assign bus.sram_din = wr_hs_s ? bus.in_data : '0;
`else
  assign cmd_is_wr_s  = 1'b0;
  assign wr_hs_s      = 1'b0;
  assign bus.sram_wr  = 1'b0;
  assign bus.sram_din = '0;
`endif

  // The address only moves on an actual access; otherwise the last one is held.
  assign bus.sram_addr = (issue_s | wr_hs_s) ? ptr_r : addr_hold_r;

  // Next-state and read-issue decision; a read is issued only if its word is sure to have a FIFO slot.
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          if (bus.cmd_len == '0) begin
            state_nx_s = FINISH;
          end else if (cmd_is_wr_s) begin
            state_nx_s = WRITE;
          end else begin
            state_nx_s = READ;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      READ: begin
        issue_s = (remain_r != '0) &&
                  (stream_occupancy(fifo_count_s, inflight_r, pop_s) < 3'(SRAM_STREAM_FIFO_DEPTH));
        if (pop_s && head_last_s) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s = state_r;
        end
      end
`ifdef SRAM_STREAM_WR_EN
      WRITE: begin
        if (wr_hs_s && (remain_r == LEN_WIDTH'(1))) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s = state_r;
        end
      end
`endif
      FINISH: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command pointer/counter and read-latency tracking; the pointer wraps at the SRAM depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r           <= '0;
      remain_r        <= '0;
      addr_hold_r     <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (cmd_hs_s) begin
        ptr_r    <= bus.cmd_addr;
        remain_r <= bus.cmd_len;
      end else if (issue_s || wr_hs_s) begin
        ptr_r    <= ptr_r + ADDR_WIDTH'(1);
        remain_r <= remain_r - LEN_WIDTH'(1);
      end else begin
        ptr_r    <= ptr_r;
        remain_r <= remain_r;
      end
      if (issue_s || wr_hs_s) begin
        addr_hold_r <= ptr_r;
      end else begin
        addr_hold_r <= addr_hold_r;
      end
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (remain_r == LEN_WIDTH'(1));
    end
  end

  sram_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (bus.sram_qout),
    .push_last (inflight_last_r),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head_data (head_data_s),
    .head_last (head_last_s)
  );

endmodule

// File: tb/tb_sram_stream.sv
// tb_sram_stream: directed bench for sram_stream with a behavioural SRAM
// (one-cycle read latency). Write tests run only with SRAM_STREAM_WR_EN.
module tb_sram_stream;

  logic clk;
  logic rst_n;
  logic mem_init;
  logic [15:0] mem [16];
  int checks;
  int errors;

  sram_stream_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LEN_WIDTH(5)) bus ();

  sram_stream #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LEN_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, write-through on sram_wr.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0100 + 16'(i);
    end else if (bus.sram_wr) begin
      mem[bus.sram_addr] <= bus.sram_din;
    end
    bus.sram_qout <= mem[bus.sram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one read command and drain it with out_ready following pat[cycle % 4].
  task automatic do_read(input logic [3:0] addr, input logic [4:0] len, input logic [3:0] pat,
                         input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_w [4];
    int got, cyc, first_cyc, occ;
    logic prev_stall;
    logic [15:0] prev_data;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
`ifdef SRAM_STREAM_WR_EN
    bus.cmd_wr    = 1'b0;
`endif
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    got = 0; cyc = 1; first_cyc = -1; prev_stall = 1'b0; prev_data = 16'h0000;
    while (got < int'(len) && cyc < 64) begin
      bus.out_ready = pat[cyc % 4];
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      occ = int'(dut.fifo_count_s) + int'(dut.inflight_r);
      check("occupancy_le2", 32'(occ <= 2), 32'd1);
      check("rd_no_write", 32'(bus.sram_wr), 32'd0);
      if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check("rd_data", 32'(bus.out_data), 32'(exp_w[got]));
        check("rd_last", 32'(bus.out_last), 32'(got == int'(len) - 1));
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("rd_count", 32'(got), 32'(len));
    check("first_valid_cycle", 32'(first_cyc), 32'd3);
    check("done_pulse", 32'(bus.done), 32'd1);
    step();
    check("done_clear", 32'(bus.done), 32'd0);
    check("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_len   = 5'd0;
    bus.out_ready = 1'b0;
`ifdef SRAM_STREAM_WR_EN
    bus.cmd_wr   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
`endif
    step();
    step();
    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sram_wr", 32'(bus.sram_wr), 32'd0);
    check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`ifdef SRAM_STREAM_WR_EN
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
`endif
    rst_n = 1'b1;
    mem_init = 1'b0;
    step();

    // Basic read, full throughput
    do_read(4'd3, 5'd4, 4'b1111, 16'h0103, 16'h0104, 16'h0105, 16'h0106);
    // Address wrap
    do_read(4'd14, 5'd4, 4'b1111, 16'h010E, 16'h010F, 16'h0100, 16'h0101);
    // Backpressure toggling
    do_read(4'd14, 5'd4, 4'b1001, 16'h010E, 16'h010F, 16'h0100, 16'h0101);

    // Zero-length command: last access was address 1, which must stay on the bus
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd9;
    bus.cmd_len   = 5'd0;
    check("len0_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_out_valid", 32'(bus.out_valid), 32'd0);
    check("len0_sram_wr", 32'(bus.sram_wr), 32'd0);
    check("len0_sram_addr", 32'(bus.sram_addr), 32'd1);
    step();
    check("len0_done_clear", 32'(bus.done), 32'd0);
    check("len0_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    check("len0_sram_addr_hold", 32'(bus.sram_addr), 32'd1);

`ifdef SRAM_STREAM_WR_EN
    // Write 0xA,0xB,0xC at 5..7 then read them back
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd5;
    bus.cmd_len   = 5'd3;
    bus.cmd_wr    = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h000A + 16'(k);
      check("wr_in_ready", 32'(bus.in_ready), 32'd1);
      check("wr_sram_wr", 32'(bus.sram_wr), 32'd1);
      check("wr_sram_addr", 32'(bus.sram_addr), 32'd5 + 32'(k));
      check("wr_sram_din", 32'(bus.sram_din), 32'h0000000A + 32'(k));
      step();
    end
    bus.in_valid = 1'b0;
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_sram_wr_off", 32'(bus.sram_wr), 32'd0);
    check("wr_in_ready_off", 32'(bus.in_ready), 32'd0);
    step();
    check("wr_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    do_read(4'd5, 5'd3, 4'b1111, 16'h000A, 16'h000B, 16'h000C, 16'h0000);
`endif

    // Reset in cycle 4 of a len 8 read
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd0;
    bus.cmd_len   = 5'd8;
    bus.out_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check("mr_c3_valid", 32'(bus.out_valid), 32'd1);
    check("mr_c3_data", 32'(bus.out_data), 32'h00000100);
    step();
    check("mr_c4_data", 32'(bus.out_data), 32'h00000101);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_done", 32'(bus.done), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    step();
    check("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mr_no_done", 32'(bus.done), 32'd0);
    check("mr_out_valid_after", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_stream.md
# sram_stream

Command-driven streamer directly upstream/downstream of the FPU's single-port SRAM (`sp_sram`):
- Accepts a (start address, length) command and turns it into consecutive SRAM reads.
- Presents the returned words as a valid/ready stream to the FPU datapath.
- Absorbs the SRAM's one-cycle read latency with a 2-entry skid FIFO, so backpressure never loses or duplicates words.
- Optionally also sinks a write stream into the SRAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 4, SRAM address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16, word width.
- `LEN_WIDTH`, ADDR_WIDTH+1, command length width.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR_WIDTH: first word address.
- `cmd_len` in LEN_WIDTH: word count; 0 is legal.
- `cmd_wr` in 1 (SRAM_STREAM_WR_EN only): 1 = write command.
- `out_valid` out 1 / `out_ready` in 1: read-data stream handshake.
- `out_data` out DATA_WIDTH: read word.
- `out_last` out 1: marks the final word of a command.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in DATA_WIDTH (SRAM_STREAM_WR_EN only): write-data stream.
- `busy` out 1: command in progress (state != IDLE).
- `done` out 1: one-cycle pulse on command completion.
- `sram_addr` out ADDR_WIDTH, `sram_din` out DATA_WIDTH, `sram_wr` out 1: drive the SRAM.
- `sram_qout` in DATA_WIDTH: SRAM read data, valid the cycle after a read is issued.

## Operation
States:
- `IDLE`: `cmd_ready`=1. On a command handshake, latch addr/len into `ptr`/`remain`.
  - len 0 → next state `FINISH`.
  - `cmd_wr`=1 → `WRITE`; otherwise → `READ`.
- `READ`: issue a read (`sram_wr`=0, `sram_addr`=`ptr`) when `remain`≠0 and fifo_count + inflight − pop < 2.
  - On issue: `ptr`+1 (mod 2**ADDR_WIDTH, wraps), `remain`−1, inflight=1 for the next cycle.
  - When inflight, `sram_qout` is pushed into the skid FIFO.
  - FIFO head drives `out_valid`/`out_data`.
  - `out_last`=1 on the head word when it is the command's final word.
  - The handshake on the last word → `FINISH`.
- `WRITE`: `in_ready`=1 while `remain`≠0.
  - Each `in` handshake, same cycle: `sram_wr`=1, `sram_addr`=`ptr`, `sram_din`=`in_data`; then `ptr`+1 (wraps), `remain`−1.
  - Last handshake → `FINISH`.
- `FINISH`: `done`=1 for exactly one cycle → `IDLE`.

Rules:
- `sram_qout` is sampled only the cycle after a read issue. It is ignored at all other times, including the X returned after writes.
- `cmd_len` > depth is legal; addresses wrap and words are re-read.
- Outside `WRITE`, `sram_wr`=0.
- Mid-operation reset: command abandoned, FIFO and inflight discarded, no `done`; `cmd_ready`=1 on the first cycle after `rst_n` rises.

## Timing
- Reset values (cycle after `rst_n` sampled low): state `IDLE`, `out_valid`=0, `out_last`=0, `done`=0, `busy`=0, `sram_wr`=0, `sram_addr`=0, `in_ready`=0, FIFO empty, `cmd_ready`=1.
- Read latency, counted from the cmd handshake at cycle 0:
  - First read issued in cycle 1.
  - Data on `sram_qout` in cycle 2.
  - `out_valid`=1 from cycle 3.
- Throughput: 1 word/cycle with `out_ready` held high. At most 2 words are buffered or in flight at any time.
- `out_valid` and `out_data` stay stable while `out_valid`=1 and `out_ready`=0.
- `done` asserts the cycle after the final out/in handshake; `cmd_ready` returns the cycle after `done`.
- len 0: `done` one cycle after the command handshake; no SRAM access.

## Configuration
- `SRAM_STREAM_WR_EN` defined:
  - `cmd_wr`, `in_valid`, `in_ready`, `in_data` and the `WRITE` state exist.
- Not defined:
  - Those ports and the `WRITE` state are absent.
  - Every command is a read.
  - `sram_din` is tied to 0 and `sram_wr` to 0.

## Structure
- Shared package `sram_stream_pkg`: state enum (IDLE, READ, WRITE, FINISH) and FIFO depth constant `SRAM_STREAM_FIFO_DEPTH`=2.
- One sub-module, `sram_stream_skid`: a 2-entry FIFO (push, pop, count, head data, last flag), parameterised on DATA_WIDTH.

## Test plan
- Preload mem[i]=0x100+i. Read at addr 3, len 4, `out_ready`=1 → 0x103..0x106; first `out_valid` at cycle 3; `out_last` on 0x106; `done` the next cycle.
- ADDR_WIDTH=4: read at addr 14, len 4 → 0x10E, 0x10F, 0x100, 0x101 (wrap).
- Same read with `out_ready` toggling 1,0,0,1 → all 4 words in order, none duplicated; fifo_count + inflight never exceeds 2.
- Read with len 0 → `done` at cycle 1, `sram_addr`/`sram_wr` untouched, no `out_valid`.
- With `SRAM_STREAM_WR_EN`: write at addr 5, len 3, data 0xA, 0xB, 0xC; then read at addr 5, len 3 → 0xA, 0xB, 0xC.
- Pull `rst_n` low in cycle 4 of a len 8 read → `out_valid`=0 next cycle, no `done`; `cmd_ready`=1 the cycle after reset is released.
